// File: rtl/scratch_wrbuf.sv
`timescale 1ns/1ps
// scratch_wrbuf
//   Posted-write buffer in front of the 16KB scratchpad RAM slave.
//   CPU writes are acknowledged in the cycle they are presented and parked in
//   a DEPTH-entry FIFO. The FIFO drains to the RAM at one entry per cycle.
//   Reads run as RD (strobe until the RAM's registered ack), then a one-cycle
//   RDONE gap in which the CPU is acked. The gap keeps RAM read acks from
//   overlapping.
//
// Parameters
//   DEPTH  write FIFO entries (power of 2, 2..16)
//   AW     byte address width
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   s_cyc_i/s_stb_i/s_we_i CPU bus cycle, strobe, write enable
//   s_sel_i/s_adr_i/s_dat_i CPU byte selects, byte address, write data
//   s_ack_o/s_dat_o        CPU acknowledge, read data (valid with a read ack)
//   m_cs_o/m_cyc_o/m_stb_o RAM chip select, cycle, strobe
//   m_we_o/m_sel_o/m_adr_o/m_dat_o  RAM write enable, selects, address, data
//   m_ack_i/m_dat_i        RAM ack (combinational write, registered read), read data
//   empty_o/full_o         FIFO status
//
// Build option
//   SCRATCH_WRBUF_RDBYPASS_EN: a read may overtake queued writes when no
//   queued entry targets the same 32-bit word. Without it, reads wait for
//   the FIFO to empty.
//
// Handshake
//   A CPU write is taken when s_cyc_i & s_stb_i & s_we_i and the FIFO is not
//   full; s_ack_o rises in that same cycle and the push happens at its edge.
//   A RAM transfer completes in any cycle with m_stb_o & m_ack_i high.
module scratch_wrbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          s_cyc_i,
    input  logic          s_stb_i,
    input  logic          s_we_i,
    input  logic [3:0]    s_sel_i,
    input  logic [AW-1:0] s_adr_i,
    input  logic [31:0]   s_dat_i,
    output logic          s_ack_o,
    output logic [31:0]   s_dat_o,
    output logic          m_cs_o,
    output logic          m_cyc_o,
    output logic          m_stb_o,
    output logic          m_we_o,
    output logic [3:0]    m_sel_o,
    output logic [AW-1:0] m_adr_o,
    output logic [31:0]   m_dat_o,
    input  logic          m_ack_i,
    input  logic [31:0]   m_dat_i,
    output logic          empty_o,
    output logic          full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 4 + AW + 32;

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_RD, ST_RDONE} state_t;
    state_t state_q, state_d;

    // Entry layout: {sel, adr, dat}
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [PW:0]   wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
    logic [EW-1:0] head;
    logic          push, pop, empty, full, rd_req, rd_hazard;
    logic [AW-1:0] rd_adr_q;
    logic [31:0]   rd_dat_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o = empty;
    assign full_o  = full;

    assign push = s_cyc_i & s_stb_i & s_we_i & ~full & ~rst_i;
    assign pop  = (state_q == ST_DRAIN) & m_ack_i & ~empty;
    assign rd_req = s_cyc_i & s_stb_i & ~s_we_i;

    assign wr_ptr_nxt = wr_ptr_q + {{PW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr_q + {{PW{1'b0}}, pop};
    assign head       = fifo_mem[rd_ptr_q[PW-1:0]];

`ifdef SCRATCH_WRBUF_RDBYPASS_EN
    // A read is blocked only by a live entry for the same word. Slots
    // outside [rd_ptr, wr_ptr) hold stale data and are masked off.
    logic [PW:0] count;
    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        rd_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - rd_ptr_q[PW-1:0]} < count) &&
                (fifo_mem[i][34 +: AW-2] == s_adr_i[AW-1:2])) begin
                rd_hazard = 1'b1;
            end
        end
    end
`else
    assign rd_hazard = ~empty;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Looking at push as well as !empty starts the drain in the
                // cycle right after the write is acked.
                if (rd_req && !rd_hazard) begin
                    state_d = ST_RD;
                end else if (!empty || push) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rd_req && !rd_hazard) begin
                    state_d = ST_RD;
                end else if (wr_ptr_nxt == rd_ptr_nxt) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (m_ack_i) begin
                    state_d = ST_RDONE;
                end
            end
            ST_RDONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_cs_o  = 1'b0;
        m_cyc_o = 1'b0;
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_sel_o = 4'h0;
        m_adr_o = '0;
        m_dat_o = 32'h0;
        case (state_q)
            ST_DRAIN: begin
                m_cs_o  = 1'b1;
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_sel_o = head[EW-1 -: 4];
                m_adr_o = head[32 +: AW];
                m_dat_o = head[31:0];
            end
            ST_RD: begin
                m_cs_o  = 1'b1;
                m_cyc_o = 1'b1;
                m_stb_o = 1'b1;
                m_sel_o = 4'hF;
                m_adr_o = rd_adr_q;
            end
            default: ;
        endcase
    end

    // The read ack is dropped if the CPU abandoned the cycle during RD.
    assign s_ack_o = push | ((state_q == ST_RDONE) & s_cyc_i & ~rst_i);
    assign s_dat_o = rd_dat_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_adr_q <= '0;
            rd_dat_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_nxt;
            rd_ptr_q <= rd_ptr_nxt;
            if (state_d == ST_RD && state_q != ST_RD) begin
                rd_adr_q <= s_adr_i;
            end
            if (state_q == ST_RD && m_ack_i) begin
                rd_dat_q <= m_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {s_sel_i, s_adr_i, s_dat_i};
        end
    end
endmodule

// File: tb/tb_scratch_wrbuf.sv
`timescale 1ns/1ps
module tb_scratch_wrbuf;
    localparam int DEPTH = 4;
    localparam int AW    = 14;
    localparam int EW    = 4 + AW + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          s_cyc, s_stb, s_we;
    logic [3:0]    s_sel;
    logic [AW-1:0] s_adr;
    logic [31:0]   s_dat;
    logic          s_ack_o;
    logic [31:0]   s_dat_o;
    logic          m_cs_o, m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]    m_sel_o;
    logic [AW-1:0] m_adr_o;
    logic [31:0]   m_dat_o;
    logic          m_ack_i;
    logic [31:0]   m_dat_i;
    logic          empty_o, full_o;

    scratch_wrbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .s_cyc_i (s_cyc),
        .s_stb_i (s_stb),
        .s_we_i  (s_we),
        .s_sel_i (s_sel),
        .s_adr_i (s_adr),
        .s_dat_i (s_dat),
        .s_ack_o (s_ack_o),
        .s_dat_o (s_dat_o),
        .m_cs_o  (m_cs_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_sel_o (m_sel_o),
        .m_adr_o (m_adr_o),
        .m_dat_o (m_dat_o),
        .m_ack_i (m_ack_i),
        .m_dat_i (m_dat_i),
        .empty_o (empty_o),
        .full_o  (full_o)
    );

    // ---------------- RAM model ----------------
    logic [31:0] ram [4096];
    logic        ram_ack_en;
    logic        rd_ack_q;
    logic [31:0] ram_rd_q;
    logic        wr_ack;

    assign wr_ack  = m_cs_o & m_cyc_o & m_stb_o & m_we_o & ram_ack_en;
    assign m_ack_i = wr_ack | rd_ack_q;
    assign m_dat_i = ram_rd_q;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    logic [31:0]   rd_exp_q[$];
    logic [31:0]   ref_mem [4096];
    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge clk) begin
        if (rst) rd_ack_q <= 1'b0;
        else     rd_ack_q <= m_cs_o & m_cyc_o & m_stb_o & ~m_we_o & ~rd_ack_q;
        ram_rd_q <= ram[m_adr_o[13:2]];
        if (!rst && wr_ack) begin
            for (int b = 0; b < 4; b++) begin
                if (m_sel_o[b]) ram[m_adr_o[13:2]][8*b +: 8] <= m_dat_o[8*b +: 8];
            end
            obs_q.push_back({m_sel_o, m_adr_o, m_dat_o});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_idle();
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_we  = 1'b0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic cpu_write(input logic [AW-1:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1;
        s_adr = adr;  s_sel = sel;  s_dat = dat;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_ack_o) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            waits++;
        end
        if (got) begin
            exp_q.push_back({sel, adr, dat});
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) ref_mem[adr[13:2]][8*b +: 8] = dat[8*b +: 8];
            end
            @(posedge clk); #1;
        end else begin
            waits = -1;
        end
    endtask

    task automatic cpu_read(input logic [AW-1:0] adr, output logic [31:0] data,
                            output int lat);
        bit got;
        got  = 1'b0;
        lat  = -1;
        data = 32'h0;
        rd_exp_q.push_back(ref_mem[adr[13:2]]);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0;
        s_adr = adr;  s_sel = 4'hF; s_dat = 32'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (s_ack_o) begin
                got  = 1'b1;
                lat  = k;
                data = s_dat_o;
                break;
            end
            @(posedge clk); #1;
        end
        if (got) begin
            @(posedge clk); #1;
        end
        cpu_idle();
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (empty_o && !m_stb_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int w;
        rst = 1'b1;
        ram_ack_en = 1'b1;
        cpu_idle();
        s_sel = 4'h0; s_adr = '0; s_dat = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (empty_o !== 1'b1 || full_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: empty=%b full=%b expected 1 0", empty_o, full_o);
        end
        n_tests++;
        if ({m_cs_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o} !== 8'h0 || m_adr_o !== '0 || m_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_ram_port: stb=%b adr=%h dat=%h expected all zero", m_stb_o, m_adr_o, m_dat_o);
        end
        n_tests++;
        if (s_ack_o !== 1'b0 || s_dat_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_cpu_port: ack=%b dat=%h expected 0 0", s_ack_o, s_dat_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Queue three writes with the RAM stalled, then reset mid-drain.
        ram_ack_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_write(14'(32'h100 + 4 * i), 4'hF, 32'h5A5A0000 + i, w);
        end
        cpu_idle();
        @(negedge clk);
        n_tests++;
        if (m_stb_o !== 1'b1 || empty_o !== 1'b0) begin
            n_fail++; $display("FAIL stalled_drain: stb=%b empty=%b expected 1 0", m_stb_o, empty_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (empty_o !== 1'b1 || m_stb_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: empty=%b stb=%b expected 1 0", empty_o, m_stb_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        ram_ack_en = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (obs_q.size() !== 0 || m_stb_o !== 1'b0 || empty_o !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_writes: ram_writes=%0d stb=%b empty=%b expected 0 0 1",
                               obs_q.size(), m_stb_o, empty_o);
        end
        exp_q.delete();
        obs_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int w, lat;
        bit ok;
        logic [31:0] d, e;
        cpu_write(14'h0010, 4'hF, 32'hDEADBEEF, w);
        n_tests++;
        if (w !== 0) begin
            n_fail++; $display("FAIL single_wr_ack: waited %0d expected 0", w);
        end
        cpu_idle();
        @(negedge clk);
        n_tests++;
        if (!(m_stb_o === 1'b1 && m_we_o === 1'b1 && m_adr_o === 14'h0010 &&
              m_dat_o === 32'hDEADBEEF && m_sel_o === 4'hF)) begin
            n_fail++; $display("FAIL single_ram_wr: stb=%b we=%b adr=%h dat=%h expected 1 1 0010 deadbeef",
                               m_stb_o, m_we_o, m_adr_o, m_dat_o);
        end
        @(posedge clk); #1;
        wait_drain(ok);
        n_tests++;
        if (!ok || obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL single_drain: ok=%b writes=%0d expected 1 %0d", ok, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            n_tests++;
            if (obs_q[0] !== exp_q[0]) begin
                n_fail++; $display("FAIL single_wr_data: got %h expected %h", obs_q[0], exp_q[0]);
            end
            void'(obs_q.pop_front()); void'(exp_q.pop_front());
        end
        // Two back-to-back reads: 3-cycle latency each, 4 cycles apart.
        for (int r = 0; r < 2; r++) begin
            cpu_read(14'h0010, d, lat);
            e = rd_exp_q.pop_front();
            n_tests++;
            if (lat !== 3) begin
                n_fail++; $display("FAIL read_latency_%0d: got %0d expected 3", r, lat);
            end
            n_tests++;
            if (d !== e) begin
                n_fail++; $display("FAIL read_data_%0d: got %h expected %h", r, d, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w;
        bit ok;
        ram_ack_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                n_tests++;
                if (full_o !== 1'b1) begin
                    n_fail++; $display("FAIL fifo_full: got %b expected 1", full_o);
                end
                ram_ack_en = 1'b1;
            end
            cpu_write(14'(32'h200 + 4 * i), 4'(($urandom_range(1, 15))), $urandom(), w);
            n_tests++;
            if (w !== ((i == 4) ? 1 : 0)) begin
                n_fail++; $display("FAIL b2b_ack_wait_%0d: got %0d expected %0d", i, w, (i == 4) ? 1 : 0);
            end
        end
        cpu_idle();
        wait_drain(ok);
        n_tests++;
        if (!ok || obs_q.size() !== 5 || exp_q.size() !== 5) begin
            n_fail++; $display("FAIL b2b_drain: ok=%b writes=%0d expected 1 5", ok, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            n_tests++;
            if (obs_q[0] !== exp_q[0]) begin
                n_fail++; $display("FAIL b2b_order: got %h expected %h", obs_q[0], exp_q[0]);
            end
            void'(obs_q.pop_front()); void'(exp_q.pop_front());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_byte_write();
        int w, lat;
        bit ok;
        logic [31:0] d, e;
        cpu_write(14'h0020, 4'hF, 32'h11223344, w);
        cpu_write(14'h0020, 4'b0100, 32'h00AB0000, w);
        cpu_idle();
        wait_drain(ok);
        n_tests++;
        if (!ok || obs_q.size() !== 2) begin
            n_fail++; $display("FAIL byte_drain: ok=%b writes=%0d expected 1 2", ok, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            n_tests++;
            if (obs_q[0] !== exp_q[0]) begin
                n_fail++; $display("FAIL byte_wr_entry: got %h expected %h", obs_q[0], exp_q[0]);
            end
            void'(obs_q.pop_front()); void'(exp_q.pop_front());
        end
        cpu_read(14'h0020, d, lat);
        e = rd_exp_q.pop_front();
        n_tests++;
        if (d !== 32'h11AB3344 || d !== e) begin
            n_fail++; $display("FAIL byte_merge: got %h expected 11ab3344", d);
        end
    endtask

    task automatic test_read_while_queued();
        int w, lat, exp_lat;
        bit ok;
        logic [31:0] d, e;
        cpu_write(14'h0080, 4'hF, 32'h0BADCAFE, w);
        cpu_idle();
        wait_drain(ok);
        exp_q.delete(); obs_q.delete();
        cpu_write(14'h0040, 4'hF, $urandom(), w);
        cpu_write(14'h0044, 4'hF, $urandom(), w);
        cpu_read(14'h0080, d, lat);
`ifdef SCRATCH_WRBUF_RDBYPASS_EN
        exp_lat = 3;
`else
        exp_lat = 4;
`endif
        e = rd_exp_q.pop_front();
        n_tests++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL queued_read_latency: got %0d expected %0d", lat, exp_lat);
        end
        n_tests++;
        if (d !== e) begin
            n_fail++; $display("FAIL queued_read_data: got %h expected %h", d, e);
        end
        wait_drain(ok);
        n_tests++;
        if (!ok || obs_q.size() !== 2) begin
            n_fail++; $display("FAIL queued_drain: ok=%b writes=%0d expected 1 2", ok, obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            n_tests++;
            if (obs_q[0] !== exp_q[0]) begin
                n_fail++; $display("FAIL queued_order: got %h expected %h", obs_q[0], exp_q[0]);
            end
            void'(obs_q.pop_front()); void'(exp_q.pop_front());
        end
    endtask

    task automatic test_abort();
        int w, lat, acks;
        bit ok;
        logic [31:0] d, e;
        cpu_write(14'h0000, 4'hF, 32'hCAFEF00D, w);
        cpu_idle();
        wait_drain(ok);
        exp_q.delete(); obs_q.delete();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 14'h0000;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (!(m_stb_o === 1'b1 && m_we_o === 1'b0 && m_sel_o === 4'hF && m_adr_o === 14'h0000)) begin
            n_fail++; $display("FAIL rd_strobe: stb=%b we=%b sel=%h adr=%h expected 1 0 f 0000",
                               m_stb_o, m_we_o, m_sel_o, m_adr_o);
        end
        @(posedge clk); #1;
        cpu_idle();
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_ack_o) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++; $display("FAIL abort_ack: got %0d acks expected 0", acks);
        end
        @(posedge clk); #1;
        cpu_read(14'h0000, d, lat);
        e = rd_exp_q.pop_front();
        n_tests++;
        if (d !== e || lat !== 3) begin
            n_fail++; $display("FAIL abort_reread: data %h lat %0d expected %h 3", d, lat, e);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_byte_write();
        test_read_while_queued();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
